log_unit_seq: RTL and testbench
===============================

// Module: log_unit_seq
// PURPOSE
//  Multi-cycle integer logarithm unit for the calculator datapath. Takes an
//  unsigned WIDTH-bit operand and returns floor or ceil of log base 2, 4 or 16.
//  Uses a start/busy/done handshake. Also flags exact powers and zero (error).
//  Sits beside the other arithmetic units and feeds the result mux and display.
// PARAMETERS
//  WIDTH  16  operand width in bits, >= 4
//  RW     5   result width in bits; 2**RW > WIDTH is required (holds ceil result WIDTH)
// PORTS
//  clk       in   1      clock, all state updates on the rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  a         in   WIDTH  unsigned operand; captured when start is accepted
//  base_sel  in   2      00 = base 2, 01 = base 4, 10 = base 16, 11 = illegal
//  ceil_en   in   1      0 = floor, 1 = ceil; captured with a
//  busy      out  1      high while the FSM is in RUN
//  done      out  1      one-cycle completion pulse
//  result    out  RW     logarithm; held until the next completion
//  exact     out  1      operand is an exact power of the base (a == 1 counts as exact)
//  err       out  1      operand is 0 or base_sel == 11; result forced to 0
// BEHAVIOUR
//  Reset: FSM = IDLE; busy, done, result, exact and err are all 0.
//   An in-flight operation is abandoned and no done pulse is produced.
//   A start that is high during rst is ignored.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: on the edge with start = 1, capture a, base_sel and ceil_en.
//     k = 1/2/4 is the per-step shift. Internal buf = a, cnt = 0, inexact = 0.
//     If a == 0 or base_sel == 11: go to DONE with err = 1, result = 0,
//       exact = 0.
//     Otherwise go to RUN.
//   RUN, one edge per step:
//     If (buf >> k) != 0: buf <= buf >> k, cnt <= cnt + 1, and
//       inexact |= (buf[k-1:0] != 0).
//     Otherwise: register err = 0 and exact = ~inexact & (buf == 1).
//       Register result = cnt + (ceil_en & ~exact). Go to DONE.
//   DONE: done = 1 for exactly this cycle, then IDLE unconditionally.
//  busy = (state == RUN). done = (state == DONE). Both are decoded from registered state.
//  Latency: with n = floor log of a, done is high in the cycle after edge n+1,
//   counted from the accepting edge. Error cases: done is high in the cycle after
//   the accepting edge.
//  start while in RUN or DONE is ignored; it is not queued.
//  Changes on a, base_sel or ceil_en after acceptance have no effect.
//  result, exact and err hold their values from completion until the next completion.
//   They are not cleared on start.
//  cnt never exceeds WIDTH-1. The ceil result is at most WIDTH, so result never wraps.
//  Non-power operands (WIDTH not a multiple of k) need no special handling.
//   The shift drops the high zeros.
// TESTING
//  1. WIDTH=16, base 2, floor, a=255 -> result 7, exact 0. busy for 8 cycles.
//     done pulses 9 cycles after the accepting edge.
//  2. Base 2, a=256: floor -> 8 with exact 1; ceil -> 8.
//     a=257: floor -> 8, ceil -> 9, exact 0.
//  3. Base 4, a=64 -> 3, exact 1. Base 16, a=16'hFFFF: floor -> 3, ceil -> 4.
//     Base 2, a=16'hFFFF: ceil -> 16.
//  4. a=0 -> err 1, result 0, done 1 cycle after accept.
//     base_sel=11, a=5 -> err 1.
//     a=1 -> result 0, exact 1, err 0, done 2 cycles after accept.
//  5. start with a=255, then start again during RUN with a=3 -> second start ignored.
//     Result 7, then a start in IDLE is accepted.
//  6. rst asserted mid-RUN -> next cycle busy 0, result 0. No done pulse.
//     A new start is accepted the cycle after rst drops.

Source files
------------

// File: rtl/log_unit_seq_if.sv
// log_unit_seq_if: start/busy/done handshake and operand/result bus of the log unit
interface log_unit_seq_if #(
  parameter int WIDTH = 16,
  parameter int RW    = 5
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [1:0]       base_sel;
  logic             ceil_en;
  logic             busy;
  logic             done;
  logic [RW-1:0]    result;
  logic             exact;
  logic             err;
  modport master (output start, a, base_sel, ceil_en, input busy, done, result, exact, err);
  modport slave  (input start, a, base_sel, ceil_en, output busy, done, result, exact, err);
endinterface

// File: rtl/log_unit_seq.sv
// log_unit_seq: multi-cycle floor/ceil log2/log4/log16 with exact-power and error flags
module log_unit_seq #(
  parameter int WIDTH = 16,
  parameter int RW    = 5
) (
  input logic            clk,
  input logic            rst,
  log_unit_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d, sh, low_mask;
  logic [RW-1:0]    cnt_q, cnt_d, result_q, result_d;
  logic [1:0]       base_q, base_d;
  logic             ceil_q, ceil_d, inexact_q, inexact_d;
  logic             exact_q, exact_d, err_q, err_d, exact_now;
  logic [2:0]       k;
  assign k         = (base_q == 2'b00) ? 3'd1 : (base_q == 2'b01) ? 3'd2 : 3'd4;
  assign sh        = buf_q >> k;
  assign low_mask  = ~({WIDTH{1'b1}} << k);
  // Remaining buf is below 2**k; exact only if it is 1 and nothing was shifted out.
  assign exact_now = ~inexact_q & (buf_q == WIDTH'(1));
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    ceil_d    = ceil_q;
    inexact_d = inexact_q;
    result_d  = result_q;
    exact_d   = exact_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        base_d    = bus.base_sel;
        ceil_d    = bus.ceil_en;
        buf_d     = bus.a;
        cnt_d     = '0;
        inexact_d = 1'b0;
        if (bus.a == '0 || bus.base_sel == 2'b11) begin
          state_d  = DONE;
          err_d    = 1'b1;
          result_d = '0;
          exact_d  = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      RUN: if (sh != '0) begin
        buf_d     = sh;
        cnt_d     = cnt_q + 1'b1;
        inexact_d = inexact_q | ((buf_q & low_mask) != '0);
      end else begin
        err_d    = 1'b0;
        exact_d  = exact_now;
        result_d = cnt_q + RW'(ceil_q & ~exact_now);
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      ceil_q    <= 1'b0;
      inexact_q <= 1'b0;
      result_q  <= '0;
      exact_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      ceil_q    <= ceil_d;
      inexact_q <= inexact_d;
      result_q  <= result_d;
      exact_q   <= exact_d;
      err_q     <= err_d;
    end
  end
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.exact  = exact_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_log_unit_seq.sv
// tb_log_unit_seq: directed vectors for log_unit_seq with hand-computed results and latencies
module tb_log_unit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  log_unit_seq_if #(.WIDTH(16), .RW(5)) bus ();
  log_unit_seq #(.WIDTH(16), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // lat counts edges from the accepting edge (inclusive) until done is seen.
  task automatic run(input logic [15:0] av, input logic [1:0] b, input logic c,
                     input int er, input int ee, input int eerr, input int elat);
    int lat, nb;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.base_sel = b; bus.ceil_en = c;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~av; bus.base_sel = ~b; bus.ceil_en = ~c;
    lat = 1; nb = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("busy_cycles", nb, (eerr != 0) ? 0 : elat - 1);
    chk("result", bus.result, er);
    chk("exact", bus.exact, ee);
    chk("err", bus.err, eerr);
    @(posedge clk); #1;
    chk("done_pulse_len", bus.done, 0);
  endtask
  initial begin
    bus.start = 1'b1; bus.a = 16'd255; bus.base_sel = 2'b00; bus.ceil_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_exact", bus.exact, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk); bus.start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", bus.busy, 0);
    run(16'd255,   2'b00, 1'b0, 7,  0, 0, 9);
    run(16'd256,   2'b00, 1'b0, 8,  1, 0, 10);
    run(16'd256,   2'b00, 1'b1, 8,  1, 0, 10);
    run(16'd257,   2'b00, 1'b0, 8,  0, 0, 10);
    run(16'd257,   2'b00, 1'b1, 9,  0, 0, 10);
    run(16'd64,    2'b01, 1'b0, 3,  1, 0, 5);
    run(16'hFFFF,  2'b10, 1'b0, 3,  0, 0, 5);
    run(16'hFFFF,  2'b10, 1'b1, 4,  0, 0, 5);
    run(16'hFFFF,  2'b00, 1'b1, 16, 0, 0, 17);
    run(16'd0,     2'b00, 1'b0, 0,  0, 1, 1);
    run(16'd2,     2'b01, 1'b1, 1,  0, 0, 2);
    run(16'd5,     2'b11, 1'b0, 0,  0, 1, 1);
    run(16'd1,     2'b00, 1'b0, 0,  1, 0, 2);
    run(16'd1,     2'b10, 1'b1, 0,  1, 0, 2);
    // start during RUN must not be queued or change the operand
    begin
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'd255; bus.base_sel = 2'b00; bus.ceil_en = 1'b0;
      @(posedge clk); #1;
      bus.a = 16'd3;
      lat = 1;
      while (!bus.done && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      bus.start = 1'b0;
      chk("ignore_lat", lat, 9);
      chk("ignore_result", bus.result, 7);
      @(posedge clk); #1;
      chk("ignore_no_requeue", bus.busy | bus.done, 0);
    end
    run(16'd3, 2'b00, 1'b0, 1, 0, 0, 3);
    // reset mid-RUN abandons the operation
    begin
      int seen;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'd255; bus.base_sel = 2'b00; bus.ceil_en = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrun_busy", bus.busy, 1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_result", bus.result, 0);
      chk("rst_mid_done", bus.done, 0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (bus.done) seen++;
      end
      chk("rst_no_done", seen, 0);
    end
    run(16'd4, 2'b01, 1'b0, 1, 1, 0, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
